memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 148 ++++++++++++++
 tb/tb_memory_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port-write / single-port-read RAM,
// with a zero-fill engine that walks every address after a CLEAR pulse.
module memory_arbiter #(
   parameter int unsigned RAM_WIDTH     = 36,
   parameter int unsigned RAM_ADDR_BITS = 9
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [1:0]                   WR_REQ,
   input  logic [2*RAM_ADDR_BITS-1:0]   WR_ADD,
   input  logic [2*RAM_WIDTH-1:0]       WR_DATA,
   output logic [1:0]                   WR_GNT,
   input  logic [1:0]                   RD_REQ,
   input  logic [2*RAM_ADDR_BITS-1:0]   RD_ADD,
   output logic [1:0]                   RD_GNT,
   output logic [1:0]                   RD_VALID,
   output logic [RAM_WIDTH-1:0]         RD_DATA,
   input  logic                         CLEAR,
   output logic                         BUSY,
   output logic                         MEM_WR_EN,
   output logic [RAM_ADDR_BITS-1:0]     MEM_WR_ADD,
   output logic [RAM_WIDTH-1:0]         MEM_IN,
   output logic [RAM_ADDR_BITS-1:0]     MEM_READ_ADD,
   input  logic [RAM_WIDTH-1:0]         MEM_OUT
);

   localparam int unsigned AW = RAM_ADDR_BITS;
   localparam int unsigned DW = RAM_WIDTH;
   localparam logic [AW-1:0] LAST_ADDR = '1;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [1:0]      rd_v1_q, rd_v1_d;
   logic [1:0]      rd_v2_q;
   logic            mem_wr_en_q, mem_wr_en_d;
   logic [AW-1:0]   mem_wr_add_q, mem_wr_add_d;
   logic [DW-1:0]   mem_in_q, mem_in_d;
   logic [AW-1:0]   mem_rd_add_q, mem_rd_add_d;
   logic            arb_ok;
   logic            wr_xfer, rd_xfer;
   logic            wr_sel, rd_sel;

   // Contention goes to the pointer; a lone requester always wins.
   function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic ptr);
      if (req == 2'b11) begin
         return ptr ? 2'b10 : 2'b01;
      end
      return req;
   endfunction

   // Grants are combinational and suppressed during reset, fill and the CLEAR pulse cycle.
   always_comb begin
      arb_ok  = !RST && (state_q == ST_IDLE) && !CLEAR;
      WR_GNT  = arb_ok ? rr_grant(WR_REQ, wr_ptr_q) : 2'b00;
      RD_GNT  = arb_ok ? rr_grant(RD_REQ, rd_ptr_q) : 2'b00;
      wr_xfer = |(WR_REQ & WR_GNT);
      rd_xfer = |(RD_REQ & RD_GNT);
      wr_sel  = WR_GNT[1];
      rd_sel  = RD_GNT[1];
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rd_v1_d      = RD_REQ & RD_GNT;
      mem_wr_en_d  = 1'b0;
      mem_wr_add_d = mem_wr_add_q;
      mem_in_d     = mem_in_q;
      mem_rd_add_d = mem_rd_add_q;

      case (state_q)
         ST_IDLE: begin
            if (CLEAR) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_xfer) begin
         wr_ptr_d     = ~wr_sel;
         mem_wr_en_d  = 1'b1;
         mem_wr_add_d = wr_sel ? WR_ADD[2*AW-1:AW] : WR_ADD[AW-1:0];
         mem_in_d     = wr_sel ? WR_DATA[2*DW-1:DW] : WR_DATA[DW-1:0];
      end

      if (rd_xfer) begin
         rd_ptr_d     = ~rd_sel;
         mem_rd_add_d = rd_sel ? RD_ADD[2*AW-1:AW] : RD_ADD[AW-1:0];
      end

      // Fill write for the address the counter will hold next cycle.
      if (state_d == ST_CLEAR) begin
         mem_wr_en_d  = 1'b1;
         mem_wr_add_d = cnt_d;
         mem_in_d     = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         rd_v1_q      <= 2'b00;
         rd_v2_q      <= 2'b00;
         mem_wr_en_q  <= 1'b0;
         mem_wr_add_q <= '0;
         mem_in_q     <= '0;
         mem_rd_add_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_v1_q      <= rd_v1_d;
         rd_v2_q      <= rd_v1_q;
         mem_wr_en_q  <= mem_wr_en_d;
         mem_wr_add_q <= mem_wr_add_d;
         mem_in_q     <= mem_in_d;
         mem_rd_add_q <= mem_rd_add_d;
      end
   end

   // Read data is the RAM's registered output, qualified by the returning tag.
   assign RD_VALID     = rd_v2_q;
   assign RD_DATA      = (|rd_v2_q) ? MEM_OUT : '0;
   assign BUSY         = (state_q == ST_CLEAR);
   assign MEM_WR_EN    = mem_wr_en_q;
   assign MEM_WR_ADD   = mem_wr_add_q;
   assign MEM_IN       = mem_in_q;
   assign MEM_READ_ADD = mem_rd_add_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a read-first behavioural RAM attached.
`timescale 1ns/1ps
module tb_memory_arbiter;

   localparam int unsigned AW    = 9;
   localparam int unsigned DW    = 36;
   localparam int unsigned DEPTH = 512;

   logic            CLK = 1'b0;
   logic            RST;
   logic [1:0]      WR_REQ, RD_REQ, WR_GNT, RD_GNT, RD_VALID;
   logic [2*AW-1:0] WR_ADD, RD_ADD;
   logic [2*DW-1:0] WR_DATA;
   logic [DW-1:0]   RD_DATA, MEM_IN;
   logic [DW-1:0]   mem_out = '0;
   logic            CLEAR, BUSY, MEM_WR_EN;
   logic [AW-1:0]   MEM_WR_ADD, MEM_READ_ADD;

   typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; int cyc;} wr_exp_t;
   typedef struct {logic [1:0] tag; logic [DW-1:0] data; int cyc;} rd_exp_t;

   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];
   int      total = 0;
   int      bad = 0;
   int      cyc = 0;
   int      nb;

   logic [DW-1:0] mem [DEPTH];
   logic          mem_loaded = 1'b0;

   memory_arbiter #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) dut (
      .CLK(CLK), .RST(RST),
      .WR_REQ(WR_REQ), .WR_ADD(WR_ADD), .WR_DATA(WR_DATA), .WR_GNT(WR_GNT),
      .RD_REQ(RD_REQ), .RD_ADD(RD_ADD), .RD_GNT(RD_GNT),
      .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
      .CLEAR(CLEAR), .BUSY(BUSY),
      .MEM_WR_EN(MEM_WR_EN), .MEM_WR_ADD(MEM_WR_ADD), .MEM_IN(MEM_IN),
      .MEM_READ_ADD(MEM_READ_ADD), .MEM_OUT(mem_out)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Read-first RAM preloaded with addr+0x100 so pre-fill contents are known.
   always @(posedge CLK) begin
      if (!mem_loaded) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i) + 36'h100;
         mem_loaded <= 1'b1;
      end else begin
         if (MEM_WR_EN) mem[MEM_WR_ADD] <= MEM_IN;
         mem_out <= mem[MEM_READ_ADD];
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected responses as the DUT presents them.
   always @(negedge CLK) begin
      rd_exp_t re;
      wr_exp_t we;
      if (RD_VALID != 2'b00) begin
         if (rd_q.size() == 0) begin
            check("rd_unexpected", 64'(RD_VALID), 64'(0));
         end else begin
            re = rd_q.pop_front();
            check("rd_tag", 64'(RD_VALID), 64'(re.tag));
            check("rd_data", 64'(RD_DATA), 64'(re.data));
            check("rd_latency", 64'(cyc), 64'(re.cyc));
         end
      end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
         re = rd_q.pop_front();
         check("rd_missing", 64'(RD_VALID), 64'(re.tag));
      end
      if (!BUSY) begin
         if (MEM_WR_EN) begin
            if (wr_q.size() == 0) begin
               check("wr_unexpected", 64'(MEM_WR_EN), 64'(0));
            end else begin
               we = wr_q.pop_front();
               check("wr_addr", 64'(MEM_WR_ADD), 64'(we.addr));
               check("wr_data", 64'(MEM_IN), 64'(we.data));
               check("wr_latency", 64'(cyc), 64'(we.cyc));
            end
         end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
            we = wr_q.pop_front();
            check("wr_missing", 64'(MEM_WR_EN), 64'(1));
         end
      end
   end

   // One arbitration cycle: drive, check grants, queue expected responses.
   task automatic slot(input logic [1:0] wreq, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [DW-1:0] wd1, input logic [1:0] ewg,
                       input logic [1:0] rreq, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic [1:0] erg, input logic [DW-1:0] erd, input string nm);
      WR_REQ  = wreq;
      WR_ADD  = {wa1, wa0};
      WR_DATA = {wd1, wd0};
      RD_REQ  = rreq;
      RD_ADD  = {ra1, ra0};
      @(negedge CLK);
      check({nm, "_wgnt"}, 64'(WR_GNT), 64'(ewg));
      check({nm, "_rgnt"}, 64'(RD_GNT), 64'(erg));
      if (ewg != 2'b00) wr_q.push_back('{ewg[1] ? wa1 : wa0, ewg[1] ? wd1 : wd0, cyc + 1});
      if (erg != 2'b00) rd_q.push_back('{erg, erd, cyc + 2});
      @(posedge CLK); #1;
      WR_REQ = 2'b00;
      RD_REQ = 2'b00;
   endtask

   task automatic wr1(input logic [1:0] req, input logic [AW-1:0] a, input logic [DW-1:0] d);
      slot(req, a, d, a, d, req, 2'b00, '0, '0, 2'b00, '0, "wr");
   endtask

   task automatic rd1(input logic [1:0] req, input logic [AW-1:0] a, input logic [DW-1:0] d);
      slot(2'b00, '0, '0, '0, '0, 2'b00, req, a, a, req, d, "rd");
   endtask

   task automatic idle();
      slot(2'b00, '0, '0, '0, '0, 2'b00, 2'b00, '0, '0, 2'b00, '0, "idle");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; CLEAR = 1'b0;
      WR_REQ = 2'b11; RD_REQ = 2'b11;
      WR_ADD = '0; WR_DATA = '0; RD_ADD = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_wgnt", 64'(WR_GNT), 64'(0));
      check("rst_rgnt", 64'(RD_GNT), 64'(0));
      check("rst_busy", 64'(BUSY), 64'(0));
      check("rst_wren", 64'(MEM_WR_EN), 64'(0));
      check("rst_wradd", 64'(MEM_WR_ADD), 64'(0));
      check("rst_memin", 64'(MEM_IN), 64'(0));
      check("rst_rdadd", 64'(MEM_READ_ADD), 64'(0));
      check("rst_rdvalid", 64'(RD_VALID), 64'(0));
      check("rst_rddata", 64'(RD_DATA), 64'(0));
      @(posedge CLK); #1;
      RST = 1'b0; WR_REQ = 2'b00; RD_REQ = 2'b00;

      // Transfers just before CLEAR still complete; reads see pre-fill contents.
      slot(2'b01, 9'd3, 36'h55, 9'd0, 36'h0, 2'b01, 2'b01, 9'd9, 9'd0, 2'b01, 36'h109, "preclr0");
      slot(2'b10, 9'd0, 36'h0, 9'd4, 36'h66, 2'b10, 2'b10, 9'd0, 9'd10, 2'b10, 36'h10A, "preclr1");

      WR_REQ = 2'b11; RD_REQ = 2'b11; CLEAR = 1'b1;
      @(negedge CLK);
      check("clrpulse_wgnt", 64'(WR_GNT), 64'(0));
      check("clrpulse_rgnt", 64'(RD_GNT), 64'(0));
      @(posedge CLK); #1;
      CLEAR = 1'b0;
      nb = 0;
      for (int k = 0; k < 600; k++) begin
         @(negedge CLK);
         if (!BUSY) break;
         check("fill_wren", 64'(MEM_WR_EN), 64'(1));
         check("fill_addr", 64'(MEM_WR_ADD), 64'(nb));
         check("fill_data", 64'(MEM_IN), 64'(0));
         check("fill_wgnt", 64'(WR_GNT), 64'(0));
         check("fill_rgnt", 64'(RD_GNT), 64'(0));
         CLEAR = (nb == 200);
         nb++;
      end
      WR_REQ = 2'b00; RD_REQ = 2'b00; CLEAR = 1'b0;
      check("busy_cycles", 64'(nb), 64'(512));
      @(posedge CLK); #1;

      // Full-rate readback with requesters alternating every cycle.
      for (int i = 0; i < DEPTH; i++) rd1((i % 2 == 1) ? 2'b10 : 2'b01, AW'(i), '0);

      // Contended writes alternate 0,1,0,1.
      slot(2'b11, 9'h10, 36'hA10, 9'h20, 36'hB20, 2'b01, 2'b00, '0, '0, 2'b00, '0, "rr0");
      slot(2'b11, 9'h11, 36'hA11, 9'h20, 36'hB20, 2'b10, 2'b00, '0, '0, 2'b00, '0, "rr1");
      slot(2'b11, 9'h11, 36'hA11, 9'h21, 36'hB21, 2'b01, 2'b00, '0, '0, 2'b00, '0, "rr2");
      slot(2'b11, 9'h12, 36'hA12, 9'h21, 36'hB21, 2'b10, 2'b00, '0, '0, 2'b00, '0, "rr3");

      wr1(2'b01, 9'd5, 36'hABC);
      idle();
      rd1(2'b01, 9'h10, 36'hA10);
      rd1(2'b10, 9'd5, 36'hABC);

      // Same-cycle write and read to one address returns the old word.
      slot(2'b10, 9'd0, 36'h0, 9'd7, 36'h123, 2'b10, 2'b01, 9'd7, 9'd0, 2'b01, 36'h0, "coll");
      idle();
      rd1(2'b10, 9'd7, 36'h123);
      rd1(2'b01, 9'h21, 36'hB21);

      wr1(2'b01, 9'd150, 36'h150A);
      wr1(2'b10, 9'd300, 36'h300B);
      wr1(2'b01, 9'd50, 36'h50C);
      slot(2'b11, 9'd60, 36'h60, 9'd61, 36'h61, 2'b10, 2'b11, 9'd150, 9'd300, 2'b10, 36'h300B, "cont0");
      slot(2'b11, 9'd60, 36'h60, 9'd61, 36'h61, 2'b01, 2'b11, 9'd50, 9'd150, 2'b01, 36'h50C, "cont1");
      repeat (3) idle();

      // Reset during the fill at address 99 leaves the upper addresses alone.
      CLEAR = 1'b1;
      @(posedge CLK); #1;
      CLEAR = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge CLK);
         if (BUSY && MEM_WR_ADD == 9'd99) break;
      end
      check("rst_at_addr", 64'(MEM_WR_ADD), 64'(99));
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("midrst_busy", 64'(BUSY), 64'(0));
      check("midrst_wren", 64'(MEM_WR_EN), 64'(0));
      @(posedge CLK); #1;

      slot(2'b11, 9'd400, 36'h400D, 9'd401, 36'h401E, 2'b01, 2'b11, 9'd150, 9'd300, 2'b01, 36'h150A, "postrst");
      rd1(2'b10, 9'd300, 36'h300B);
      rd1(2'b01, 9'd60, 36'h0);
      rd1(2'b10, 9'd61, 36'h0);
      rd1(2'b01, 9'd400, 36'h400D);
      rd1(2'b10, 9'd50, 36'h0);
      rd1(2'b01, 9'd5, 36'h0);
      repeat (4) idle();

      check("wr_queue_empty", 64'(wr_q.size()), 64'(0));
      check("rd_queue_empty", 64'(rd_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
